// File: rtl/pcs_rx_decoder.sv
// 64b/66b receive decoder: turns descrambled 66-bit blocks into XGMII words, using one block of
// lookahead to validate terminates, substituting E/LF words and counting decode errors.
module pcs_rx_decoder #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_block_lock,
    input  logic                     i_valid,
    input  logic [1:0]               i_hdr,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic [DATA_WIDTH-1:0]    o_xgmii_data,
    output logic [CTRL_WIDTH-1:0]    o_xgmii_ctrl,
    output logic                     o_valid,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

    localparam logic [DATA_WIDTH-1:0] LF_DATA = 64'h0100009C_0100009C;
    localparam logic [CTRL_WIDTH-1:0] LF_CTRL = 8'h11;
    localparam logic [DATA_WIDTH-1:0] E_DATA  = 64'hFEFEFEFE_FEFEFEFE;
    localparam logic [CTRL_WIDTH-1:0] E_CTRL  = 8'hFF;

    typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_t;
    typedef enum logic [2:0] {CL_C, CL_S, CL_D, CL_T, CL_E} blk_class_t;

    rx_state_t               r_state;
    rx_state_t               w_state_nxt;
    blk_class_t              w_cls;
    logic                    r_vld_p1;
    logic [1:0]              r_hdr_p1;
    logic [DATA_WIDTH-1:0]   r_data_p1;
    logic                    r_vld_p2;
    logic [DATA_WIDTH-1:0]   r_xgmii_data_p2;
    logic [CTRL_WIDTH-1:0]   r_xgmii_ctrl_p2;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic [DATA_WIDTH-1:0]   w_dec_data;
    logic [CTRL_WIDTH-1:0]   w_dec_ctrl;
    logic [3:0]              w_term;
    logic                    w_err;
    logic                    w_advance;

    function automatic logic is_idle_blk(input logic [1:0] hdr, input logic [DATA_WIDTH-1:0] data);
        logic ok;
        ok = (hdr == 2'b10) && (data[7:0] == 8'h1E);
        for (int i = 0; i < 8; i++) begin
            if ((data[8+7*i +: 7] != 7'h00) && (data[8+7*i +: 7] != 7'h1E)) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic is_start_blk(input logic [1:0] hdr, input logic [DATA_WIDTH-1:0] data);
        return (hdr == 2'b10) && ((data[7:0] == 8'h78) || (data[7:0] == 8'h33));
    endfunction

    // {is_terminate, number of data bytes}
    function automatic logic [3:0] term_code(input logic [7:0] t);
        case (t)
            8'h87:   return 4'b1000;
            8'h99:   return 4'b1001;
            8'hAA:   return 4'b1010;
            8'hB4:   return 4'b1011;
            8'hCC:   return 4'b1100;
            8'hD2:   return 4'b1101;
            8'hE1:   return 4'b1110;
            8'hFF:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    assign w_term    = term_code(r_data_p1[7:0]);
    assign w_advance = i_block_lock && i_valid && r_vld_p1;

    always_comb begin
        w_cls = CL_E;
        if (r_hdr_p1 == 2'b01)
            w_cls = CL_D;
        else if (is_idle_blk(r_hdr_p1, r_data_p1))
            w_cls = CL_C;
        else if (is_start_blk(r_hdr_p1, r_data_p1))
            w_cls = CL_S;
        else if ((r_hdr_p1 == 2'b10) && w_term[3] &&
                 (is_idle_blk(i_hdr, i_data) || is_start_blk(i_hdr, i_data)))
            w_cls = CL_T;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= RX_INIT;
        else if (!i_block_lock)
            r_state <= RX_INIT;
        else if (w_advance)
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = RX_E;
        case (r_state)
            RX_INIT, RX_C, RX_T: begin
                if (w_cls == CL_C)      w_state_nxt = RX_C;
                else if (w_cls == CL_S) w_state_nxt = RX_D;
            end
            RX_D: begin
                if (w_cls == CL_D)      w_state_nxt = RX_D;
                else if (w_cls == CL_T) w_state_nxt = RX_T;
            end
            RX_E: begin
                if (w_cls == CL_C)      w_state_nxt = RX_C;
                else if (w_cls == CL_D) w_state_nxt = RX_D;
                else if (w_cls == CL_T) w_state_nxt = RX_T;
            end
            default: w_state_nxt = RX_E;
        endcase
    end

    always_comb begin
        w_err      = (w_state_nxt == RX_E);
        w_dec_data = E_DATA;
        w_dec_ctrl = E_CTRL;
        if (!w_err) begin
            case (w_cls)
                CL_C: begin
                    for (int i = 0; i < 8; i++)
                        w_dec_data[8*i +: 8] = (r_data_p1[8+7*i +: 7] == 7'h00) ? 8'h07 : 8'hFE;
                end
                CL_S: begin
                    if (r_data_p1[7:0] == 8'h78) begin
                        w_dec_data = {r_data_p1[63:8], 8'hFB};
                        w_dec_ctrl = 8'h01;
                    end else begin
                        w_dec_data = {r_data_p1[63:40], 8'hFB, 32'h07070707};
                        w_dec_ctrl = 8'h1F;
                    end
                end
                CL_D: begin
                    w_dec_data = r_data_p1;
                    w_dec_ctrl = 8'h00;
                end
                CL_T: begin
                    // data bytes sit one byte above their lane because of the type field
                    for (int i = 0; i < 8; i++) begin
                        if (i < int'(w_term[2:0])) begin
                            w_dec_data[8*i +: 8] = r_data_p1[8+8*i +: 8];
                            w_dec_ctrl[i]        = 1'b0;
                        end else if (i == int'(w_term[2:0])) begin
                            w_dec_data[8*i +: 8] = 8'hFD;
                        end else begin
                            w_dec_data[8*i +: 8] = 8'h07;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // stage 1: capture block, stage 2: decode with lookahead and register outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vld_p1        <= 1'b0;
            r_hdr_p1        <= 2'b00;
            r_data_p1       <= '0;
            r_vld_p2        <= 1'b0;
            r_xgmii_data_p2 <= LF_DATA;
            r_xgmii_ctrl_p2 <= LF_CTRL;
            r_err_cnt       <= '0;
        end else if (!i_block_lock) begin
            r_vld_p1        <= 1'b0;
            r_hdr_p1        <= 2'b00;
            r_data_p1       <= '0;
            r_vld_p2        <= i_valid;
            r_xgmii_data_p2 <= LF_DATA;
            r_xgmii_ctrl_p2 <= LF_CTRL;
        end else begin
            r_vld_p2 <= w_advance;
            if (i_valid) begin
                r_vld_p1  <= 1'b1;
                r_hdr_p1  <= i_hdr;
                r_data_p1 <= i_data;
            end
            if (w_advance) begin
                r_xgmii_data_p2 <= w_dec_data;
                r_xgmii_ctrl_p2 <= w_dec_ctrl;
                if (w_err && (r_err_cnt != '1))
                    r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign o_xgmii_data = r_xgmii_data_p2;
    assign o_xgmii_ctrl = r_xgmii_ctrl_p2;
    assign o_valid      = r_vld_p2;
    assign o_err_cnt    = r_err_cnt;

endmodule
